i2c_eeprom_slave: RTL and testbench

I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

---
 rtl/i2c_slv_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 48 ++++
 rtl/i2c_eeprom_slave.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slv_pkg.sv
// Shared definitions for the I2C EEPROM-style slave: FSM states, default
// device address and the bus-level ACK/NACK bit values.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    AHI,
    ACK_AHI,
    ALO,
    ACK_ALO,
    WDATA,
    ACK_W,
    RDATA,
    MACK
  } state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk domain and derives SCL edges plus
// START/STOP conditions from the synchronized lines.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] line_in;
  logic [1:0] line_now;
  logic [1:0] line_prev;

  assign line_in = {sda_in, scl_in};

  // One extra flop past the synchronizer holds the previous value for edge detection.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic [SYNC_STAGES:0] chain_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          chain_reg <= '1;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-1:0], line_in[gi]};
        end
      end

      assign line_now[gi]  = chain_reg[SYNC_STAGES-1];
      assign line_prev[gi] = chain_reg[SYNC_STAGES];
    end
  endgenerate

  assign sda_s     = line_now[1];
  assign scl_rise  =  line_now[0] & ~line_prev[0];
  assign scl_fall  = ~line_now[0] &  line_prev[0];
  assign start_det =  line_now[0] & line_prev[0] &  line_prev[1] & ~line_now[1];
  assign stop_det  =  line_now[0] & line_prev[0] & ~line_prev[1] &  line_now[1];

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C slave exposing a byte-wide memory addressed by a 16-bit pointer.
// Define I2C_SLV_AUTOINC_EN to advance the pointer after every data byte.
module i2c_eeprom_slave
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
  parameter int         MEM_AW      = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        busy,
  output logic        wr_done,
  output logic        rd_done,
  output logic [15:0] mem_ptr
);

  localparam int          MEM_DEPTH  = 1 << MEM_AW;
  localparam logic [16:0] IDX_MASK17 = (17'd1 << MEM_AW) - 17'd1;
  localparam logic [15:0] IDX_MASK   = IDX_MASK17[15:0];

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rstn      (rstn),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  addr_hi_reg, addr_hi_next;
  logic [15:0] mem_ptr_reg, mem_ptr_next;
  logic        rw_reg, rw_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        busy_reg, busy_next;
  logic        wr_done_reg, wr_done_next;
  logic        rd_done_reg, rd_done_next;
  logic        mem_we;
  logic [7:0]  rd_data_reg;
  logic [15:0] ptr_after_byte;

  logic [7:0] mem [MEM_DEPTH];
  logic [MEM_AW-1:0] mem_idx;

  assign mem_idx = mem_ptr_reg[MEM_AW-1:0];

  // Only the indexed bits wrap; upper pointer bits ride along untouched.
`ifdef I2C_SLV_AUTOINC_EN
  assign ptr_after_byte = (mem_ptr_reg & ~IDX_MASK) | ((mem_ptr_reg + 16'd1) & IDX_MASK);
`else
  assign ptr_after_byte = mem_ptr_reg;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= shift_reg;
    end
    rd_data_reg <= mem[mem_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      addr_hi_reg <= '0;
      mem_ptr_reg <= '0;
      rw_reg      <= 1'b0;
      sda_oe_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      wr_done_reg <= 1'b0;
      rd_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      addr_hi_reg <= addr_hi_next;
      mem_ptr_reg <= mem_ptr_next;
      rw_reg      <= rw_next;
      sda_oe_reg  <= sda_oe_next;
      busy_reg    <= busy_next;
      wr_done_reg <= wr_done_next;
      rd_done_reg <= rd_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    addr_hi_next = addr_hi_reg;
    mem_ptr_next = mem_ptr_reg;
    rw_next      = rw_reg;
    sda_oe_next  = sda_oe_reg;
    busy_next    = busy_reg;
    wr_done_next = 1'b0;
    rd_done_next = 1'b0;
    mem_we       = 1'b0;

    // Bus conditions win over any SCL edge seen in the same cycle.
    if (stop_det) begin
      state_next   = IDLE;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
      bit_cnt_next = '0;
    end else if (start_det) begin
      state_next   = DEV;
      sda_oe_next  = 1'b0;
      bit_cnt_next = '0;
    end else begin
      unique case (state_reg)
        DEV, AHI, ALO, WDATA: begin
          if (scl_rise && bit_cnt_reg != 4'd8) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd8) begin
            bit_cnt_next = '0;
            sda_oe_next  = ~ACK_BIT;
            if (state_reg == DEV) begin
              if (shift_reg[7:1] == DEV_ADDR) begin
                state_next = ACK_DEV;
                busy_next  = 1'b1;
                rw_next    = shift_reg[0];
              end else begin
                state_next  = IDLE;
                sda_oe_next = 1'b0;
                busy_next   = 1'b0;
              end
            end else if (state_reg == AHI) begin
              state_next   = ACK_AHI;
              addr_hi_next = shift_reg;
            end else if (state_reg == ALO) begin
              state_next   = ACK_ALO;
              mem_ptr_next = {addr_hi_reg, shift_reg};
            end else begin
              state_next   = ACK_W;
              mem_we       = 1'b1;
              wr_done_next = 1'b1;
              mem_ptr_next = ptr_after_byte;
            end
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            bit_cnt_next = '0;
            if (rw_reg) begin
              state_next  = RDATA;
              shift_next  = rd_data_reg;
              sda_oe_next = ~rd_data_reg[7];
            end else begin
              state_next  = AHI;
              sda_oe_next = 1'b0;
            end
          end
        end
        ACK_AHI: begin
          if (scl_fall) begin
            state_next  = ALO;
            sda_oe_next = 1'b0;
          end
        end
        ACK_ALO, ACK_W: begin
          if (scl_fall) begin
            state_next  = WDATA;
            sda_oe_next = 1'b0;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 4'd7) begin
              state_next   = MACK;
              sda_oe_next  = 1'b0;
              rd_done_next = 1'b1;
              mem_ptr_next = ptr_after_byte;
            end else begin
              bit_cnt_next = bit_cnt_reg + 4'd1;
              shift_next   = {shift_reg[6:0], 1'b0};
              sda_oe_next  = ~shift_reg[6];
            end
          end
        end
        MACK: begin
          if (scl_rise && sda_s == NACK_BIT) begin
            state_next = IDLE;
          end else if (scl_fall) begin
            state_next   = RDATA;
            bit_cnt_next = '0;
            shift_next   = rd_data_reg;
            sda_oe_next  = ~rd_data_reg[7];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sda_oe  = sda_oe_reg;
  assign busy    = busy_reg;
  assign wr_done = wr_done_reg;
  assign rd_done = rd_done_reg;
  assign mem_ptr = mem_ptr_reg;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bus-level bench: a bit-banged I2C master drives the slave and results are
// compared against a byte-array memory model with a 16-bit pointer.
module tb_i2c_eeprom_slave;
  import i2c_slv_pkg::*;

  localparam int Q = 8;
  localparam logic [7:0] DEV_W = 8'hA0;
  localparam logic [7:0] DEV_R = 8'hA1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_oe, busy, wr_done, rd_done;
  logic [15:0] mem_ptr;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_eeprom_slave #(
    .DEV_ADDR    (7'h50),
    .MEM_AW      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .scl_in  (scl_m),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_done (wr_done),
    .rd_done (rd_done),
    .mem_ptr (mem_ptr)
  );

  int wr_cnt = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (wr_done) wr_cnt <= wr_cnt + 1;
    if (rd_done) rd_cnt <= rd_cnt + 1;
    if (sda_oe)  oe_cnt <= oe_cnt + 1;
  end

  logic [7:0]  model_mem [256];
  bit          model_valid [256];
  logic [15:0] model_ptr;
  logic [7:0]  wbuf [4];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_advance();
`ifdef I2C_SLV_AUTOINC_EN
    model_ptr[7:0] = model_ptr[7:0] + 8'd1;
`endif
  endfunction

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hq();
    scl_m = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    hq();
    scl_m = 1'b1; hq(); hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; hq();
    scl_m = 1'b1; hq();
    ack = ~sda_bus; hq();
    scl_m = 1'b0; hq();
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hq();
      scl_m = 1'b1; hq();
      d[i] = sda_bus; hq();
      scl_m = 1'b0; hq();
    end
    send_bit(~m_ack);
  endtask

  task automatic addr_phase(input logic [15:0] a, input string tag);
    logic ack;
    bus_start();
    write_byte(DEV_W, ack);   check({tag, "_ack_dev"}, 32'(ack), 32'd1);
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    write_byte(a[15:8], ack); check({tag, "_ack_ahi"}, 32'(ack), 32'd1);
    write_byte(a[7:0], ack);  check({tag, "_ack_alo"}, 32'(ack), 32'd1);
    model_ptr = a;
  endtask

  task automatic do_write(input logic [15:0] a, input int n, input string tag);
    logic ack;
    int   wr0;
    wr0 = wr_cnt;
    addr_phase(a, tag);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check({tag, "_ack_data"}, 32'(ack), 32'd1);
      model_mem[model_ptr[7:0]]   = wbuf[i];
      model_valid[model_ptr[7:0]] = 1'b1;
      model_advance();
    end
    bus_stop(); hq();
    check({tag, "_wr_pulses"}, 32'(wr_cnt - wr0), 32'(n));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_ptr"}, 32'(mem_ptr), 32'(model_ptr));
    $display("write addr=%04h bytes=%0d ptr=%04h", a, n, mem_ptr);
  endtask

  task automatic do_read(input logic [15:0] a, input int n, input string tag);
    logic       ack;
    logic [7:0] d;
    int         rd0;
    addr_phase(a, tag);
    bus_start();
    write_byte(DEV_R, ack); check({tag, "_ack_devr"}, 32'(ack), 32'd1);
    rd0 = rd_cnt;
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, d);
      if (model_valid[model_ptr[7:0]])
        check({tag, "_data"}, 32'(d), 32'(model_mem[model_ptr[7:0]]));
      model_advance();
    end
    check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(n));
    check({tag, "_idle"}, 32'(dut.state_reg), 32'(IDLE));
    bus_stop(); hq();
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_ptr"}, 32'(mem_ptr), 32'(model_ptr));
    $display("read addr=%04h bytes=%0d last=%02h ptr=%04h", a, n, d, mem_ptr);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ack;
    logic [15:0] a;
    int          n, wr0, oe0;

    for (int i = 0; i < 256; i++) model_valid[i] = 1'b0;
    model_ptr = 16'h0000;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sda_oe",  32'(sda_oe),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    check("rst_mem_ptr", 32'(mem_ptr), 32'd0);
    rstn = 1'b1;
    hq();
    $display("reset released");

    // Single-byte write then random read of it
    wbuf[0] = 8'h7B;
    do_write(16'h0001, 1, "wr7b");
    do_read(16'h0001, 1, "rd7b");

    // Foreign device address
    oe0 = oe_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    check("foreign_ack", 32'(ack), 32'd0);
    check("foreign_oe", 32'(oe_cnt - oe0), 32'd0);
    check("foreign_busy", 32'(busy), 32'd0);
    bus_stop(); hq();
    $display("foreign address 0x51 frame done");

    // STOP after half a data byte
    addr_phase(16'h0001, "part");
    wr0 = wr_cnt;
    for (int k = 0; k < 4; k++) send_bit(k[0]);
    bus_stop(); hq();
    check("part_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    check("part_idle", 32'(dut.state_reg), 32'(IDLE));
    check("part_busy", 32'(busy), 32'd0);
    $display("partial byte aborted by STOP");
    do_read(16'h0001, 1, "part_rb");

    // Pointer wrap at the top of the indexed range
    wbuf[0] = 8'h11;
    do_write(16'h0000, 1, "pre0");
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    do_write(16'h00FF, 2, "wrap");
    do_read(16'h00FF, 1, "wrap_ff");
    do_read(16'h0000, 1, "wrap_00");

    // Randomized write/read-back pairs
    for (int t = 0; t < 4; t++) begin
      a = 16'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(a, n, "rnd_w");
      do_read(a, n, "rnd_r");
    end

    // Reset while the slave drives a 0 data bit
    wbuf[0] = 8'h00;
    do_write(16'h0005, 1, "rst_pre");
    addr_phase(16'h0005, "rst_rd");
    bus_start();
    write_byte(DEV_R, ack);
    check("rst_rd_ack", 32'(ack), 32'd1);
    for (int k = 0; k < 50 && sda_oe !== 1'b1; k++) @(negedge clk);
    check("rst_oe_driving", 32'(sda_oe), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_oe",  32'(sda_oe),  32'd0);
    check("rst_async_ptr", 32'(mem_ptr), 32'd0);
    check("rst_async_busy", 32'(busy),   32'd0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    hq(); hq();
    rstn = 1'b1;
    hq();
    model_ptr = 16'h0000;
    check("rst_idle", 32'(dut.state_reg), 32'(IDLE));
    $display("reset asserted mid-read");
    wbuf[0] = 8'h3C;
    do_write(16'h0003, 1, "post_rst_w");
    do_read(16'h0003, 1, "post_rst_r");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
